// File: rtl/muldiv_seq.sv
// Multi-cycle 32x32 multiply / 32/32 divide sequencer for the EX stage.
// Signed ops work on magnitudes; the result sign is restored in the FIX state.
module muldiv_seq (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        start,
   input  logic [1:0]  op,
   input  logic [31:0] a,
   input  logic [31:0] b,
   input  logic        flush,
   output logic        busy,
   output logic        stall,
   output logic        done,
   output logic [31:0] hi,
   output logic [31:0] lo,
   output logic        div_by_zero
);
   localparam int DATA_W = 32;

   typedef enum logic [2:0] {S_IDLE, S_PREP, S_CALC, S_FIX, S_DONE} state_t;

   state_t              state, state_nxt;
   logic [4:0]          cnt;
   logic [1:0]          op_q;
   logic [DATA_W-1:0]   a_q, b_q;
   logic [DATA_W-1:0]   dvs;
   logic [DATA_W:0]     acc;
   logic [DATA_W-1:0]   mq;
   logic                neg_res, neg_rem;

   function automatic logic [DATA_W-1:0] neg32(input logic [DATA_W-1:0] x);
      return ~x + 1'b1;
   endfunction

   function automatic logic [2*DATA_W-1:0] neg64(input logic [2*DATA_W-1:0] x);
      return ~x + 1'b1;
   endfunction

   logic accept, is_div, sgn, dz;
   logic [DATA_W-1:0] mag_a, mag_b;
   assign accept = (state == S_IDLE) && start && !flush;
   assign is_div = op_q[1];
   assign sgn    = !op_q[0];
   assign dz     = is_div && (b_q == '0);
   assign mag_a  = (sgn && a_q[DATA_W-1]) ? neg32(a_q) : a_q;
   assign mag_b  = (sgn && b_q[DATA_W-1]) ? neg32(b_q) : b_q;

   // One shift-add (multiply) or one restoring trial subtract (divide) per CALC cycle
   logic [DATA_W:0] add_t, shifted, trial;
   logic            ge;
   assign add_t   = acc + (mq[0] ? {1'b0, dvs} : '0);
   assign shifted = {acc[DATA_W-1:0], mq[DATA_W-1]};
   assign trial   = shifted - {1'b0, dvs};
   assign ge      = (shifted >= {1'b0, dvs});

   logic [2*DATA_W-1:0] prod, prod_s;
   logic [DATA_W-1:0]   res_hi, res_lo;
   always_comb begin
      prod   = {acc[DATA_W-1:0], mq};
      prod_s = neg_res ? neg64(prod) : prod;
      if (is_div) begin
         res_hi = neg_rem ? neg32(acc[DATA_W-1:0]) : acc[DATA_W-1:0];
         res_lo = neg_res ? neg32(mq) : mq;
      end else begin
         res_hi = prod_s[2*DATA_W-1:DATA_W];
         res_lo = prod_s[DATA_W-1:0];
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= S_IDLE;
      else        state <= state_nxt;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)                          cnt <= '0;
      else if (state == S_CALC && !flush)  cnt <= cnt + 5'd1;
      else                                 cnt <= '0;
   end

   always_comb begin
      state_nxt = state;
      busy      = (state != S_IDLE);
      done      = (state == S_DONE);
      stall     = (busy && !done) || (start && !busy && !flush);
      case (state)
         S_IDLE: if (start) state_nxt = S_PREP;
         S_PREP: state_nxt = dz ? S_DONE : S_CALC;
         S_CALC: if (cnt == 5'd31) state_nxt = S_FIX;
         S_FIX:  state_nxt = S_DONE;
         S_DONE: state_nxt = S_IDLE;
         default: state_nxt = S_IDLE;
      endcase
      if (flush) state_nxt = S_IDLE;
   end

   // Operand and iteration registers carry no reset; they are always loaded before use
   always_ff @(posedge clk) begin
      if (accept) begin
         op_q <= op;
         a_q  <= a;
         b_q  <= b;
      end
      case (state)
         S_PREP: begin
            acc     <= '0;
            mq      <= mag_a;
            dvs     <= mag_b;
            neg_res <= sgn && (a_q[DATA_W-1] ^ b_q[DATA_W-1]);
            neg_rem <= sgn && is_div && a_q[DATA_W-1];
         end
         S_CALC: begin
            if (is_div) begin
               acc <= ge ? trial : shifted;
               mq  <= {mq[DATA_W-2:0], ge};
            end else begin
               acc <= {1'b0, add_t[DATA_W:1]};
               mq  <= {add_t[0], mq[DATA_W-1:1]};
            end
         end
         default: ;
      endcase
   end

   // Results change only on a completed operation; a flushed one leaves them alone
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         hi          <= '0;
         lo          <= '0;
         div_by_zero <= 1'b0;
      end else begin
         if (accept) div_by_zero <= 1'b0;
         if (!flush) begin
            if (state == S_FIX) begin
               hi <= res_hi;
               lo <= res_lo;
            end else if (state == S_PREP && dz) begin
               hi          <= a_q;
               lo          <= '1;
               div_by_zero <= 1'b1;
            end
         end
      end
   end

endmodule

// File: tb/tb_muldiv_seq.sv
// Directed bench for muldiv_seq: a cycle-level reference model checked every cycle,
// plus hand-computed literal results for each operation.
module tb_muldiv_seq;
   logic        clk = 1'b0;
   logic        rst_n, start, flush;
   logic [1:0]  op;
   logic [31:0] a, b;
   logic        busy, stall, done, div_by_zero;
   logic [31:0] hi, lo;

   int vectors = 0;
   int miscompares = 0;

   muldiv_seq dut (
      .clk(clk), .rst_n(rst_n), .start(start), .op(op), .a(a), .b(b), .flush(flush),
      .busy(busy), .stall(stall), .done(done), .hi(hi), .lo(lo), .div_by_zero(div_by_zero)
   );

   always #5 clk = ~clk;

   initial begin
      #300000;
      $display("FAIL watchdog: simulation did not finish, got timeout required completion");
      $fatal(1, "watchdog");
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %h, required %h", name, act, exp);
      end
   endtask

   // Reference: what {hi,lo} must be for an op, from plain arithmetic
   function automatic logic [63:0] ref_res(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
      longint sx, sy, q, r;
      logic [63:0] u;
      sx = longint'($signed(x));
      sy = longint'($signed(y));
      case (o)
         2'b00: begin q = sx * sy; return q; end
         2'b01: begin u = {32'd0, x} * {32'd0, y}; return u; end
         2'b10: begin
            if (y == 0) return {x, 32'hFFFF_FFFF};
            q = sx / sy; r = sx % sy;
            return {r[31:0], q[31:0]};
         end
         default: begin
            if (y == 0) return {x, 32'hFFFF_FFFF};
            return {x % y, x / y};
         end
      endcase
   endfunction

   // Model: mk = cycles since the accepting edge (-1 when idle)
   int          mk = -1;
   logic        m_isdz = 1'b0, m_dbz = 1'b0;
   logic [31:0] m_hi = '0, m_lo = '0;
   logic [63:0] m_res = '0;

   always @(negedge clk) begin
      logic e_busy, e_done, e_stall;
      int   fin;
      if (!rst_n) begin
         mk = -1; m_hi = '0; m_lo = '0; m_dbz = 1'b0;
      end
      fin     = m_isdz ? 1 : 34;
      e_busy  = (mk >= 0);
      e_done  = (mk == fin);
      e_stall = (e_busy && !e_done) || (start && !e_busy && !flush);
      vectors++;
      if ({busy, done, stall, div_by_zero, hi, lo} !== {e_busy, e_done, e_stall, m_dbz, m_hi, m_lo}) begin
         miscompares++;
         $display("FAIL cycle t=%0t: got busy=%b done=%b stall=%b dbz=%b hi=%h lo=%h, required busy=%b done=%b stall=%b dbz=%b hi=%h lo=%h",
                  $time, busy, done, stall, div_by_zero, hi, lo, e_busy, e_done, e_stall, m_dbz, m_hi, m_lo);
      end
      if (rst_n) begin
         if (flush) mk = -1;
         else if (mk < 0) begin
            if (start) begin
               mk = 0; m_dbz = 1'b0;
               m_res = ref_res(op, a, b);
               m_isdz = op[1] && (b == 0);
            end
         end else begin
            mk++;
            if (mk == fin) begin
               m_hi = m_res[63:32]; m_lo = m_res[31:0];
               if (m_isdz) m_dbz = 1'b1;
            end else if (mk > fin) mk = -1;
         end
      end
   end

   task automatic issue(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
      @(posedge clk); #1;
      start = 1'b1; op = o; a = x; b = y;
      @(posedge clk); #1;
      start = 1'b0;
   endtask

   task automatic run_op(input string name, input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                         input logic [31:0] ehi, input logic [31:0] elo, input logic edbz, input int elat,
                         output int nbusy);
      int got;
      got = 0; nbusy = 0;
      issue(o, x, y);
      for (int i = 1; i <= 60; i++) begin
         @(negedge clk);
         if (busy) nbusy++;
         if (done) begin got = i; break; end
      end
      check({name, " latency"}, got, elat);
      check({name, " hi"}, hi, ehi);
      check({name, " lo"}, lo, elo);
      check({name, " dbz"}, {31'd0, div_by_zero}, {31'd0, edbz});
   endtask

   initial begin
      int nb;
      rst_n = 1'b0; start = 1'b0; flush = 1'b0; op = 2'b00; a = '0; b = '0;
      @(negedge clk);
      check("reset busy", {31'd0, busy}, 32'd0);
      check("reset stall", {31'd0, stall}, 32'd0);
      check("reset hilo", hi | lo, 32'd0);
      @(posedge clk); #1 rst_n = 1'b1;

      run_op("multu max", 2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0, 35, nb);
      check("multu busy cycles", nb, 35);
      run_op("mult -3*7", 2'b00, 32'hFFFF_FFFD, 32'd7, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0, 35, nb);
      run_op("mult min*min", 2'b00, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0, 1'b0, 35, nb);
      run_op("div -7/2", 2'b10, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0, 35, nb);
      run_op("divu 7/2", 2'b11, 32'd7, 32'd2, 32'd1, 32'd3, 1'b0, 35, nb);
      run_op("div min/-1", 2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 32'h8000_0000, 1'b0, 35, nb);
      run_op("divu 5/0", 2'b11, 32'd5, 32'd0, 32'd5, 32'hFFFF_FFFF, 1'b1, 2, nb);
      run_op("multu 2*3", 2'b01, 32'd2, 32'd3, 32'd0, 32'd6, 1'b0, 35, nb);

      // Flush mid-CALC with an ignored start poke beforehand
      issue(2'b01, 32'd3, 32'd4);
      repeat (5) @(posedge clk);
      #1 start = 1'b1; op = 2'b11; a = 32'd9; b = 32'd9;
      @(posedge clk); #1 start = 1'b0;
      repeat (4) @(posedge clk);
      #1 flush = 1'b1;
      @(posedge clk); #1 flush = 1'b0;
      @(negedge clk);
      check("flush busy", {31'd0, busy}, 32'd0);
      check("flush hi", hi, 32'd0);
      check("flush lo", lo, 32'd6);

      // start and flush together in IDLE: nothing accepted
      @(posedge clk); #1 start = 1'b1; flush = 1'b1; op = 2'b01; a = 32'd1; b = 32'd1;
      @(posedge clk); #1 start = 1'b0; flush = 1'b0;
      @(negedge clk);
      check("start+flush busy", {31'd0, busy}, 32'd0);

      // Asynchronous reset mid-CALC
      issue(2'b01, 32'h1234, 32'h10);
      repeat (10) @(posedge clk);
      #1 rst_n = 1'b0;
      #1;
      check("rst busy", {31'd0, busy}, 32'd0);
      check("rst stall", {31'd0, stall}, 32'd0);
      check("rst done", {31'd0, done}, 32'd0);
      check("rst hi", hi, 32'd0);
      check("rst lo", lo, 32'd0);
      @(posedge clk); #1 rst_n = 1'b1;
      run_op("divu 100/7", 2'b11, 32'd100, 32'd7, 32'd2, 32'd14, 1'b0, 35, nb);

      repeat (3) @(negedge clk);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
